// File: rtl/sram_req_adapter.sv
// sram_req_adapter
//   Bridges a valid/ready request port and a read-response port onto a
//   single-port synchronous SRAM. After reset it can zero-fill the SRAM. It
//   then accepts one request per cycle, with credit-based flow control into
//   a 2-entry read-response FIFO.
//
// Ports
//   Clk_CI, Rst_RI            clock, synchronous active-high reset
//   ReqValid_SI/ReqReady_SO   request handshake
//   ReqWe_SI                  1 = write, 0 = read
//   ReqAddr_DI, ReqWData_DI   request address / write data
//   RspValid_SO/RspReady_SI   read-response handshake
//   RspRData_DO               read-response data (FIFO head)
//   InitDone_SO               high while accepting requests (RUN)
//   SramCSel_SO, SramWrEn_SO  SRAM chip select / write enable
//   SramBEn_SO                SRAM byte enables (all ones)
//   SramAddr_DO, SramWrData_DO SRAM address / write data
//   SramRdData_DI             SRAM read data, valid the cycle after a read
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | reset state; SRAM and request port quiet for one cycle
// INIT  | zero-fill sweep, one address per cycle from 0 to DEPTH-1
// RUN   | request port open, InitDone_SO high
module sram_req_adapter #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic                Clk_CI,
  input  logic                Rst_RI,
  input  logic                ReqValid_SI,
  output logic                ReqReady_SO,
  input  logic                ReqWe_SI,
  input  logic [ADDR_W-1:0]   ReqAddr_DI,
  input  logic [DATA_W-1:0]   ReqWData_DI,
  output logic                RspValid_SO,
  input  logic                RspReady_SI,
  output logic [DATA_W-1:0]   RspRData_DO,
  output logic                InitDone_SO,
  output logic                SramCSel_SO,
  output logic                SramWrEn_SO,
  output logic [DATA_W/8-1:0] SramBEn_SO,
  output logic [ADDR_W-1:0]   SramAddr_DO,
  output logic [DATA_W-1:0]   SramWrData_DO,
  input  logic [DATA_W-1:0]   SramRdData_DI
);

  // One extra bit so that DEPTH = 2^ADDR_W is reachable as a terminal count.
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] INIT_LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     init_cnt_q;
  logic              rd_pend_q;
  logic [DATA_W-1:0] fifo_mem_q [2];
  logic              fifo_wr_ptr_q;
  logic              fifo_rd_ptr_q;
  logic [1:0]        fifo_cnt_q;

  logic       rsp_valid;
  logic       pop;
  logic       push;
  logic       req_ready;
  logic       fire;
  logic       rd_fire;
  logic [1:0] credit_cnt;

  assign rsp_valid  = (fifo_cnt_q != 2'd0);
  assign pop        = rsp_valid && RspReady_SI;
  // The read issued last cycle has its data on SramRdData_DI now.
  assign push       = rd_pend_q;
  assign credit_cnt = fifo_cnt_q + {1'b0, rd_pend_q};

  // A pop this cycle frees a slot in time for a read fired now, which keeps
  // streaming reads at one per cycle.
  assign req_ready = (state_q == ST_RUN) && ((credit_cnt < 2'd2) || pop);
  assign fire      = ReqValid_SI && req_ready;
  assign rd_fire   = fire && !ReqWe_SI;

  assign ReqReady_SO = req_ready;
  assign RspValid_SO = rsp_valid;
  assign RspRData_DO = fifo_mem_q[fifo_rd_ptr_q];
  assign InitDone_SO = (state_q == ST_RUN);
  assign SramBEn_SO  = '1;

  always_comb begin
    SramCSel_SO   = 1'b0;
    SramWrEn_SO   = 1'b0;
    SramAddr_DO   = ReqAddr_DI;
    SramWrData_DO = ReqWData_DI;
    case (state_q)
      ST_INIT: begin
        SramCSel_SO   = 1'b1;
        SramWrEn_SO   = 1'b1;
        SramAddr_DO   = init_cnt_q[ADDR_W-1:0];
        SramWrData_DO = '0;
      end
      ST_RUN: begin
        SramCSel_SO = fire;
        SramWrEn_SO = fire && ReqWe_SI;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q       <= ST_IDLE;
      init_cnt_q    <= '0;
      rd_pend_q     <= 1'b0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= INIT_ZERO ? ST_INIT : ST_RUN;
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + CW'(1);
          if (init_cnt_q == INIT_LAST) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN:  ;
        default: state_q <= ST_IDLE;
      endcase

      rd_pend_q <= rd_fire;

      if (push) begin
        fifo_mem_q[fifo_wr_ptr_q] <= SramRdData_DI;
        fifo_wr_ptr_q             <= ~fifo_wr_ptr_q;
      end
      if (pop) begin
        fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: ;
      endcase
    end
  end

  // The credit rule must make a push onto a full FIFO impossible.
  a_no_overflow : assert property (@(posedge Clk_CI) disable iff (Rst_RI)
    !(push && !pop && (fifo_cnt_q == 2'd2)));

endmodule

// File: tb/tb_sram_req_adapter.sv
// tb_sram_req_adapter
//   Directed bench for sram_req_adapter with a behavioural SRAM attached.
//   A second instance with INIT_ZERO=0 shares clock and reset.
module tb_sram_req_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        init_done;
  logic        sram_csel;
  logic        sram_we;
  logic [7:0]  sram_ben;
  logic [7:0]  sram_addr;
  logic [63:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic [63:0] sram_mem [256];

  logic        nz_req_ready;
  logic        nz_rsp_valid;
  logic [63:0] nz_rsp_rdata;
  logic        nz_init_done;
  logic        nz_csel;
  logic        nz_we;
  logic [7:0]  nz_ben;
  logic [7:0]  nz_addr;
  logic [63:0] nz_wdata;
  logic        nz_lo;
  logic [7:0]  nz_addr_in;
  logic [63:0] nz_data_in;

  int checks = 0;
  int errors = 0;

  assign nz_lo      = 1'b0;
  assign nz_addr_in = 8'h00;
  assign nz_data_in = 64'h0;

  sram_req_adapter #(.DATA_W(64), .ADDR_W(8), .DEPTH(256), .INIT_ZERO(1'b1)) dut (
    .Clk_CI        (clk),
    .Rst_RI        (rst),
    .ReqValid_SI   (req_valid),
    .ReqReady_SO   (req_ready),
    .ReqWe_SI      (req_we),
    .ReqAddr_DI    (req_addr),
    .ReqWData_DI   (req_wdata),
    .RspValid_SO   (rsp_valid),
    .RspReady_SI   (rsp_ready),
    .RspRData_DO   (rsp_rdata),
    .InitDone_SO   (init_done),
    .SramCSel_SO   (sram_csel),
    .SramWrEn_SO   (sram_we),
    .SramBEn_SO    (sram_ben),
    .SramAddr_DO   (sram_addr),
    .SramWrData_DO (sram_wdata),
    .SramRdData_DI (sram_rdata)
  );

  sram_req_adapter #(.DATA_W(64), .ADDR_W(8), .DEPTH(256), .INIT_ZERO(1'b0)) dut_nz (
    .Clk_CI        (clk),
    .Rst_RI        (rst),
    .ReqValid_SI   (nz_lo),
    .ReqReady_SO   (nz_req_ready),
    .ReqWe_SI      (nz_lo),
    .ReqAddr_DI    (nz_addr_in),
    .ReqWData_DI   (nz_data_in),
    .RspValid_SO   (nz_rsp_valid),
    .RspReady_SI   (nz_lo),
    .RspRData_DO   (nz_rsp_rdata),
    .InitDone_SO   (nz_init_done),
    .SramCSel_SO   (nz_csel),
    .SramWrEn_SO   (nz_we),
    .SramBEn_SO    (nz_ben),
    .SramAddr_DO   (nz_addr),
    .SramWrData_DO (nz_wdata),
    .SramRdData_DI (nz_data_in)
  );

  // Behavioural SRAM; non-zero contents during reset make a missed
  // zero-fill visible on later reads.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= ~64'(i);
    end else if (sram_csel) begin
      if (sram_we) sram_mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00;
    req_wdata = 64'h0; rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready",     64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_csel",      64'(sram_csel), 64'd0);
    check("rst_wren",      64'(sram_we),   64'd0);
    check("rst_rdata",     rsp_rdata,      64'd0);
    check("rst_ben",       64'(sram_ben),  64'hFF);
    check("nz_rst_done",   64'(nz_init_done), 64'd0);
    rst = 1'b0;

    // Zero-fill sweep
    for (int i = 0; i < 256; i++) begin
      @(negedge clk); #1;
      check("init_csel",  64'(sram_csel),  64'd1);
      check("init_wren",  64'(sram_we),    64'd1);
      check("init_addr",  64'(sram_addr),  64'(i));
      check("init_wdata", sram_wdata,      64'd0);
      check("init_ready", 64'(req_ready),  64'd0);
      check("init_done",  64'(init_done),  64'd0);
      check("nz_no_sram", 64'({nz_csel, nz_we}), 64'd0);
      if (i == 0) check("nz_done_2nd", 64'(nz_init_done), 64'd1);
    end
    @(negedge clk); #1;
    check("run_done",  64'(init_done), 64'd1);
    check("run_ready", 64'(req_ready), 64'd1);
    check("run_csel",  64'(sram_csel), 64'd0);

    // Write then read the same address on the next cycle
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h12; req_wdata = 64'hDEADBEEF_01234567;
    #1;
    check("wr_ready", 64'(req_ready),  64'd1);
    check("wr_csel",  64'(sram_csel),  64'd1);
    check("wr_wren",  64'(sram_we),    64'd1);
    check("wr_addr",  64'(sram_addr),  64'h12);
    check("wr_wdata", sram_wdata,      64'hDEADBEEF_01234567);
    @(negedge clk);
    req_we = 1'b0;
    #1;
    check("rd_ready", 64'(req_ready),  64'd1);
    check("rd_csel",  64'(sram_csel),  64'd1);
    check("rd_wren",  64'(sram_we),    64'd0);
    check("rd_addr",  64'(sram_addr),  64'h12);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("lat1_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk); #1;
    check("lat2_valid", 64'(rsp_valid), 64'd1);
    check("lat2_data",  rsp_rdata,      64'hDEADBEEF_01234567);
    @(negedge clk); #1;
    check("post_valid", 64'(rsp_valid), 64'd0);

    // Streaming: fill 0..7, then 8 back-to-back reads
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'(i);
      req_wdata = 64'h1111_0000_0000_0000 | 64'(i);
      #1;
      check("strm_wr_ready", 64'(req_ready), 64'd1);
    end
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      req_valid = (c < 8); req_we = 1'b0; req_addr = 8'(c);
      #1;
      if (c < 8) check("strm_ready", 64'(req_ready), 64'd1);
      if (c >= 2 && c < 10) begin
        check("strm_valid", 64'(rsp_valid), 64'd1);
        check("strm_data",  rsp_rdata, 64'h1111_0000_0000_0000 | 64'(c - 2));
      end else begin
        check("strm_idle", 64'(rsp_valid), 64'd0);
      end
    end

    // Backpressure
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 8'h12;
    #1;
    check("bp_ready0", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_addr = 8'h05;
    #1;
    check("bp_ready1", 64'(req_ready), 64'd1);
    check("bp_valid1", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    req_addr = 8'h07;
    #1;
    check("bp_ready2", 64'(req_ready), 64'd0);
    check("bp_valid2", 64'(rsp_valid), 64'd1);
    check("bp_data2",  rsp_rdata,      64'hDEADBEEF_01234567);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("bp_hold_ready", 64'(req_ready), 64'd0);
      check("bp_hold_valid", 64'(rsp_valid), 64'd1);
      check("bp_hold_data",  rsp_rdata,      64'hDEADBEEF_01234567);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("bp_pop_ready", 64'(req_ready), 64'd1);
    check("bp_pop_valid", 64'(rsp_valid), 64'd1);
    check("bp_pop_data0", rsp_rdata,      64'hDEADBEEF_01234567);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("bp_valid_1", 64'(rsp_valid), 64'd1);
    check("bp_data1",   rsp_rdata,      64'h1111_0000_0000_0005);
    @(negedge clk); #1;
    check("bp_valid_2", 64'(rsp_valid), 64'd1);
    check("bp_data_a2", rsp_rdata,      64'h1111_0000_0000_0007);
    @(negedge clk); #1;
    check("bp_empty",     64'(rsp_valid), 64'd0);
    check("bp_ready_end", 64'(req_ready), 64'd1);

    // Reset with one entry in the FIFO and a read in flight
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 8'h12;
    #1;
    check("mr_ready0", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_addr = 8'h05;
    #1;
    check("mr_ready1", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    #1;
    check("mr_pre_valid", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mr_valid", 64'(rsp_valid), 64'd0);
    check("mr_done",  64'(init_done), 64'd0);
    check("mr_ready", 64'(req_ready), 64'd0);
    check("mr_csel",  64'(sram_csel), 64'd0);
    check("mr_rdata", rsp_rdata,      64'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk); #1;
      check("mr_init_addr",  64'(sram_addr), 64'(i));
      check("mr_init_csel",  64'(sram_csel), 64'd1);
      check("mr_init_valid", 64'(rsp_valid), 64'd0);
    end
    @(negedge clk); #1;
    check("mr_run_done",  64'(init_done), 64'd1);
    check("mr_run_valid", 64'(rsp_valid), 64'd0);
    check("mr_run_ready", 64'(req_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_req_adapter.md
SRAM_REQ_ADAPTER -- requirements
Module: sram_req_adapter

Interface
REQ-001 Parameters SHALL be as follows.
- DATA_W, default 64: SRAM word width in bits; must be a multiple of 8.
- ADDR_W, default 8: address width in bits.
- DEPTH, default 256: number of SRAM words to initialise.
- INIT_ZERO, default 1: 1 = zero-fill the SRAM after reset; 0 = skip the fill.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning).
- Clk_CI, in, 1: the single clock.
- Rst_RI, in, 1: synchronous, active-high reset.
- ReqValid_SI, in, 1: request valid.
- ReqReady_SO, out, 1: request ready.
- ReqWe_SI, in, 1: 1 = write, 0 = read.
- ReqAddr_DI, in, ADDR_W: request address.
- ReqWData_DI, in, DATA_W: write data.
- RspValid_SO, out, 1: read response valid.
- RspReady_SI, in, 1: read response ready.
- RspRData_DO, out, DATA_W: read response data.
- InitDone_SO, out, 1: high once the block is accepting requests.
- SramCSel_SO, out, 1: SRAM chip select, active-high.
- SramWrEn_SO, out, 1: SRAM write enable, active-high.
- SramBEn_SO, out, DATA_W/8: SRAM byte enables; constant all-ones.
- SramAddr_DO, out, ADDR_W: SRAM address.
- SramWrData_DO, out, DATA_W: SRAM write data.
- SramRdData_DI, in, DATA_W: SRAM read data; valid the cycle after a read select.

Function
REQ-003 The block SHALL have three states: IDLE (reset state), INIT and RUN.
REQ-004 State transitions SHALL be as follows.
- IDLE -> INIT after one cycle when INIT_ZERO=1.
- IDLE -> RUN after one cycle when INIT_ZERO=0.
- INIT -> RUN after the write to address DEPTH-1.
REQ-005 In IDLE, SramCSel_SO, SramWrEn_SO, ReqReady_SO and InitDone_SO SHALL be 0.
REQ-006 In INIT, the block SHALL write 0 to one address per cycle, ascending from 0 (SramCSel_SO=1, SramWrEn_SO=1, SramWrData_DO=0), taking exactly DEPTH cycles.
REQ-007 In INIT, ReqReady_SO SHALL be 0.
REQ-008 InitDone_SO SHALL be 1 in RUN and only in RUN.
REQ-009 A request fires on a cycle where ReqValid_SI && ReqReady_SO.
REQ-010 In RUN, the SRAM outputs SHALL follow the request combinationally on that cycle.
- SramCSel_SO = fire.
- SramWrEn_SO = fire && ReqWe_SI.
- SramAddr_DO = ReqAddr_DI.
- SramWrData_DO = ReqWData_DI.
REQ-011 ReqReady_SO SHALL NOT depend on ReqValid_SI or ReqWe_SI.
REQ-012 A write SHALL produce no response.
REQ-013 A read fired in cycle T SHALL have SramRdData_DI captured at the end of cycle T+1 into a 2-entry response FIFO.
REQ-014 RspValid_SO SHALL be asserted from cycle T+2 at the earliest; minimum read latency is 2 cycles.
REQ-015 Responses SHALL be returned in request order.
- RspRData_DO = FIFO head.
- An entry pops on RspValid_SO && RspReady_SI.
REQ-016 Credit rule: count = FIFO occupancy + reads in flight (0 or 1). In RUN, ReqReady_SO = (count < 2) || (RspValid_SO && RspReady_SI).
REQ-017 With RspReady_SI held high, back-to-back reads SHALL sustain one accepted request per cycle.
REQ-018 The response FIFO SHALL never overflow; a push onto a full FIFO is a design error and shall be asserted against.
REQ-019 A push and a pop in the same cycle SHALL leave occupancy unchanged, with correct data ordering.
REQ-020 RspValid_SO and RspRData_DO SHALL hold stable while RspReady_SI is 0.
REQ-021 A read fired the cycle after a write to the same address SHALL return the newly written data.
REQ-022 Address wrap SHALL be natural modulo 2^ADDR_W; the INIT counter SHALL be ADDR_W+1 bits wide so that DEPTH = 2^ADDR_W terminates.

Reset
REQ-023 While Rst_RI=1 at a clock edge, the block SHALL enter IDLE, flush the FIFO, drop any read in flight and clear the INIT counter.
REQ-024 Outputs in the cycle after reset SHALL be ReqReady_SO=0, RspValid_SO=0, InitDone_SO=0, SramCSel_SO=0 and SramWrEn_SO=0.
REQ-025 RspRData_DO SHALL reset to 0.
REQ-026 A reset asserted mid-INIT or mid-RUN SHALL restart the sequence from IDLE.
REQ-027 Data returned by the SRAM after a reset for a pre-reset read SHALL be discarded.

Verification
REQ-028 Reset init (DEPTH=256, INIT_ZERO=1): release reset -> 1 IDLE cycle, then 256 cycles with SramCSel_SO=SramWrEn_SO=1 and addresses 0..255 with data 0, then InitDone_SO=1 and ReqReady_SO=1.
REQ-029 Write/read: write 0xDEADBEEF_01234567 to address 0x12, then read 0x12 the next cycle -> RspValid_SO exactly 2 cycles after the read fires, RspRData_DO=0xDEADBEEF_01234567.
REQ-030 Streaming: 8 back-to-back reads of addresses 0..7 with RspReady_SI=1 -> ReqReady_SO stays 1 and 8 in-order responses arrive on consecutive cycles.
REQ-031 Backpressure: RspReady_SI=0 while issuing reads -> exactly 2 reads accepted, then ReqReady_SO=0; raise RspReady_SI -> both responses delivered in order and ReqReady_SO returns to 1 in the same cycle as the first pop.
REQ-032 Mid-flight reset: assert Rst_RI one cycle after a read fires with the FIFO holding 1 entry -> no RspValid_SO after reset, InitDone_SO=0, and the INIT sweep restarts at address 0.
REQ-033 INIT_ZERO=0: release reset -> InitDone_SO=1 on the 2nd cycle after release, with no SRAM writes issued.
